// File: rtl/pc_call_stack.sv
`default_nettype none
// ============================================================================
// Module   : pc_call_stack
// Brief    : Parametrised return-address stack for the CALL/RET path.
//            Circular storage with full/empty status, drop-or-wrap overflow
//            policy, push+pop replace-top, and sticky overflow/underflow.
// Revision : 1.0 - initial release
// ============================================================================
module pc_call_stack #(
    parameter int ADDR_WIDTH       = 12,
    parameter int DEPTH            = 8,
    parameter bit WRAP_ON_OVERFLOW = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ADDR_WIDTH-1:0]    push_data,
    input  logic                     err_clr,
    output logic [ADDR_WIDTH-1:0]    top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE    = PTR_W'(1);

    // Per-cycle operation after resolving push/pop against full/empty.
    typedef enum logic [2:0] {
        OP_IDLE       = 3'd0,
        OP_PUSH       = 3'd1,  // push into a stack with room
        OP_PUSH_DROP  = 3'd2,  // push into a full stack, discarded
        OP_PUSH_WRAP  = 3'd3,  // push into a full stack, oldest lost
        OP_POP        = 3'd4,  // pop a non-empty stack
        OP_POP_UNDER  = 3'd5,  // pop an empty stack
        OP_REPLACE    = 3'd6,  // push+pop on a non-empty stack
        OP_PUSH_UNDER = 3'd7   // push+pop on an empty stack
    } op_t;

    logic [ADDR_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wp;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic [PTR_W-1:0]      w_wp_m1;
    op_t                   w_op;
    logic [PTR_W-1:0]      w_wp_nxt;
    logic [CNT_W-1:0]      w_count_nxt;
    logic                  w_we;
    logic [PTR_W-1:0]      w_waddr;
    logic                  w_ovf_ev;
    logic                  w_unf_ev;
    logic                  w_clear;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_COUNT);
    // Index of the current top entry; wraps naturally at PTR_W bits.
    assign w_wp_m1 = r_wp - c_PTR_ONE;
    assign w_clear = rst | init;

    // Classify the requested operation against the current occupancy.
    always_comb begin
        w_op = OP_IDLE;
        if (push && pop) begin
            w_op = w_empty ? OP_PUSH_UNDER : OP_REPLACE;
        end else if (push) begin
            if (!w_full) begin
                w_op = OP_PUSH;
            end else if (WRAP_ON_OVERFLOW) begin
                w_op = OP_PUSH_WRAP;
            end else begin
                w_op = OP_PUSH_DROP;
            end
        end else if (pop) begin
            w_op = w_empty ? OP_POP_UNDER : OP_POP;
        end
    end

    // Next pointer/count, storage write and error events for the operation.
    always_comb begin
        w_wp_nxt    = r_wp;
        w_count_nxt = r_count;
        w_we        = 1'b0;
        w_waddr     = r_wp;
        w_ovf_ev    = 1'b0;
        w_unf_ev    = 1'b0;
        unique case (w_op)
            OP_IDLE: begin
            end
            OP_PUSH: begin
                w_we        = 1'b1;
                w_wp_nxt    = r_wp + c_PTR_ONE;
                w_count_nxt = r_count + c_CNT_ONE;
            end
            OP_PUSH_DROP: begin
                w_ovf_ev = 1'b1;
            end
            OP_PUSH_WRAP: begin
                // Writing at wp overwrites the oldest slot once full.
                w_we     = 1'b1;
                w_wp_nxt = r_wp + c_PTR_ONE;
                w_ovf_ev = 1'b1;
            end
            OP_POP: begin
                w_wp_nxt    = w_wp_m1;
                w_count_nxt = r_count - c_CNT_ONE;
            end
            OP_POP_UNDER: begin
                w_unf_ev = 1'b1;
            end
            OP_REPLACE: begin
                w_we    = 1'b1;
                w_waddr = w_wp_m1;
            end
            OP_PUSH_UNDER: begin
                // An empty stack cannot be full, so this is a plain push.
                w_we        = 1'b1;
                w_wp_nxt    = r_wp + c_PTR_ONE;
                w_count_nxt = r_count + c_CNT_ONE;
                w_unf_ev    = 1'b1;
            end
            default: begin
            end
        endcase
        // A clear cycle discards any concurrent push.
        if (w_clear) begin
            w_we = 1'b0;
        end
    end

    // Pointer, occupancy and sticky flags; flag set wins over err_clr.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wp        <= w_wp_nxt;
            r_count     <= w_count_nxt;
            r_overflow  <= w_ovf_ev | (r_overflow  & ~err_clr);
            r_underflow <= w_unf_ev | (r_underflow & ~err_clr);
        end
    end

    // Return-address storage; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= push_data;
        end
    end

    assign top       = w_empty ? '0 : r_mem[w_wp_m1];
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_pc_call_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_call_stack
// Brief    : Self-checking bench for pc_call_stack (ADDR_WIDTH=12, DEPTH=4).
//            Drop-mode and wrap-mode instances share stimulus; an ordered-list
//            reference model tracks both, plus a directed vector table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_call_stack;

    localparam int AW  = 12;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          s_rst, s_init, s_push, s_pop, s_clr;
    logic [AW-1:0] s_data;

    logic [AW-1:0] w_top   [2];
    logic [2:0]    w_count [2];
    logic          w_empty [2];
    logic          w_full  [2];
    logic          w_ovf   [2];
    logic          w_unf   [2];

    int n_err    = 0;
    int n_checks = 0;

    // Reference model: entries held oldest-first in m_list[d][0..size-1].
    logic [AW-1:0] m_list [2][DEP];
    int            m_size [2];
    bit            m_ovf  [2];
    bit            m_unf  [2];

    typedef struct {
        bit            rst, init, push, pop, clr;
        logic [AW-1:0] data;
        int            cnt;
        logic [AW-1:0] top;
        bit            e, f, o, u;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    pc_call_stack #(.ADDR_WIDTH(AW), .DEPTH(DEP), .WRAP_ON_OVERFLOW(1'b0)) u_dut0 (
        .clk(clk), .rst(s_rst), .init(s_init), .push(s_push), .pop(s_pop),
        .push_data(s_data), .err_clr(s_clr), .top(w_top[0]), .count(w_count[0]),
        .empty(w_empty[0]), .full(w_full[0]), .overflow(w_ovf[0]), .underflow(w_unf[0])
    );

    pc_call_stack #(.ADDR_WIDTH(AW), .DEPTH(DEP), .WRAP_ON_OVERFLOW(1'b1)) u_dut1 (
        .clk(clk), .rst(s_rst), .init(s_init), .push(s_push), .pop(s_pop),
        .push_data(s_data), .err_clr(s_clr), .top(w_top[1]), .count(w_count[1]),
        .empty(w_empty[1]), .full(w_full[1]), .overflow(w_ovf[1]), .underflow(w_unf[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int d, input bit wrap);
        bit oe, ue;
        oe = 1'b0;
        ue = 1'b0;
        if (s_rst || s_init) begin
            m_size[d] = 0;
            m_ovf[d]  = 1'b0;
            m_unf[d]  = 1'b0;
        end else begin
            if (s_push && s_pop) begin
                if (m_size[d] > 0) begin
                    m_list[d][m_size[d]-1] = s_data;
                end else begin
                    m_list[d][0] = s_data;
                    m_size[d]    = 1;
                    ue           = 1'b1;
                end
            end else if (s_push) begin
                if (m_size[d] < DEP) begin
                    m_list[d][m_size[d]] = s_data;
                    m_size[d]++;
                end else begin
                    oe = 1'b1;
                    if (wrap) begin
                        for (int i = 0; i < DEP-1; i++) m_list[d][i] = m_list[d][i+1];
                        m_list[d][DEP-1] = s_data;
                    end
                end
            end else if (s_pop) begin
                if (m_size[d] > 0) m_size[d]--;
                else ue = 1'b1;
            end
            if (s_clr) begin
                m_ovf[d] = 1'b0;
                m_unf[d] = 1'b0;
            end
            if (oe) m_ovf[d] = 1'b1;
            if (ue) m_unf[d] = 1'b1;
        end
    endtask

    task automatic check_model();
        for (int d = 0; d < 2; d++) begin
            int exp_top;
            exp_top = (m_size[d] > 0) ? int'(m_list[d][m_size[d]-1]) : 0;
            chk($sformatf("d%0d_count", d), int'(w_count[d]), m_size[d]);
            chk($sformatf("d%0d_top", d),   int'(w_top[d]),   exp_top);
            chk($sformatf("d%0d_empty", d), int'(w_empty[d]), int'(m_size[d] == 0));
            chk($sformatf("d%0d_full", d),  int'(w_full[d]),  int'(m_size[d] == DEP));
            chk($sformatf("d%0d_ovf", d),   int'(w_ovf[d]),   int'(m_ovf[d]));
            chk($sformatf("d%0d_unf", d),   int'(w_unf[d]),   int'(m_unf[d]));
        end
    endtask

    // Drive one cycle, advance the model at the edge, compare 1 time unit later.
    task automatic step(input bit r, input bit i, input bit p, input bit q,
                        input bit c, input logic [AW-1:0] dt);
        s_rst  = r;
        s_init = i;
        s_push = p;
        s_pop  = q;
        s_clr  = c;
        s_data = dt;
        @(posedge clk);
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        #1;
        check_model();
    endtask

    task automatic add_v(input bit r, input bit i, input bit p, input bit q, input bit c,
                         input logic [AW-1:0] dt, input int cnt, input logic [AW-1:0] tp,
                         input bit e, input bit f, input bit o, input bit u);
        vec_t v;
        v.rst = r; v.init = i; v.push = p; v.pop = q; v.clr = c; v.data = dt;
        v.cnt = cnt; v.top = tp; v.e = e; v.f = f; v.o = o; v.u = u;
        tbl.push_back(v);
    endtask

    initial begin
        s_rst = 1'b1; s_init = 1'b0; s_push = 1'b0; s_pop = 1'b0; s_clr = 1'b0; s_data = '0;
        for (int d = 0; d < 2; d++) begin
            m_size[d] = 0; m_ovf[d] = 1'b0; m_unf[d] = 1'b0;
        end

        // Directed vectors for the drop-mode instance:
        //     rst init push pop clr data    cnt top    e f o u
        add_v(1, 0, 0, 0, 0, 12'h000,  0, 12'h000, 1, 0, 0, 0);
        add_v(0, 0, 1, 0, 0, 12'h010,  1, 12'h010, 0, 0, 0, 0);
        add_v(0, 0, 1, 0, 0, 12'h020,  2, 12'h020, 0, 0, 0, 0);
        add_v(0, 0, 1, 0, 0, 12'h030,  3, 12'h030, 0, 0, 0, 0);
        add_v(0, 0, 1, 0, 0, 12'h040,  4, 12'h040, 0, 1, 0, 0);
        add_v(0, 0, 1, 0, 0, 12'h050,  4, 12'h040, 0, 1, 1, 0);
        add_v(0, 0, 0, 0, 1, 12'h000,  4, 12'h040, 0, 1, 0, 0);
        add_v(0, 0, 0, 1, 0, 12'h000,  3, 12'h030, 0, 0, 0, 0);
        add_v(0, 0, 0, 1, 0, 12'h000,  2, 12'h020, 0, 0, 0, 0);
        add_v(0, 0, 0, 1, 0, 12'h000,  1, 12'h010, 0, 0, 0, 0);
        add_v(0, 0, 0, 1, 0, 12'h000,  0, 12'h000, 1, 0, 0, 0);
        add_v(0, 0, 0, 1, 0, 12'h000,  0, 12'h000, 1, 0, 0, 1);
        add_v(0, 0, 1, 1, 0, 12'h077,  1, 12'h077, 0, 0, 0, 1);
        add_v(0, 0, 0, 0, 1, 12'h000,  1, 12'h077, 0, 0, 0, 0);
        add_v(0, 0, 0, 1, 0, 12'h000,  0, 12'h000, 1, 0, 0, 0);
        add_v(0, 0, 1, 1, 0, 12'h088,  1, 12'h088, 0, 0, 0, 1);
        add_v(0, 0, 0, 0, 1, 12'h000,  1, 12'h088, 0, 0, 0, 0);
        add_v(0, 0, 0, 1, 0, 12'h000,  0, 12'h000, 1, 0, 0, 0);
        add_v(0, 0, 0, 1, 1, 12'h000,  0, 12'h000, 1, 0, 0, 1);
        add_v(1, 0, 0, 0, 0, 12'h000,  0, 12'h000, 1, 0, 0, 0);
        add_v(0, 0, 1, 0, 0, 12'h100,  1, 12'h100, 0, 0, 0, 0);
        add_v(0, 0, 1, 0, 0, 12'h200,  2, 12'h200, 0, 0, 0, 0);
        add_v(0, 0, 1, 1, 0, 12'h2AA,  2, 12'h2AA, 0, 0, 0, 0);
        add_v(0, 0, 0, 1, 0, 12'h000,  1, 12'h100, 0, 0, 0, 0);
        add_v(0, 0, 1, 0, 0, 12'h300,  2, 12'h300, 0, 0, 0, 0);
        add_v(0, 0, 1, 0, 0, 12'h400,  3, 12'h400, 0, 0, 0, 0);
        add_v(0, 0, 1, 0, 0, 12'h500,  4, 12'h500, 0, 1, 0, 0);
        add_v(0, 0, 1, 0, 0, 12'h600,  4, 12'h500, 0, 1, 1, 0);
        add_v(0, 0, 0, 1, 0, 12'h000,  3, 12'h400, 0, 0, 1, 0);
        add_v(0, 1, 1, 0, 1, 12'h700,  0, 12'h000, 1, 0, 0, 0);
        add_v(0, 0, 1, 0, 0, 12'h111,  1, 12'h111, 0, 0, 0, 0);
        add_v(0, 0, 1, 0, 0, 12'h222,  2, 12'h222, 0, 0, 0, 0);
        add_v(0, 0, 1, 0, 0, 12'h333,  3, 12'h333, 0, 0, 0, 0);
        add_v(0, 0, 1, 0, 0, 12'h444,  4, 12'h444, 0, 1, 0, 0);
        add_v(0, 0, 1, 0, 0, 12'h555,  4, 12'h444, 0, 1, 1, 0);
        add_v(0, 0, 0, 1, 0, 12'h000,  3, 12'h333, 0, 0, 1, 0);
        add_v(1, 0, 1, 0, 0, 12'h666,  0, 12'h000, 1, 0, 0, 0);

        foreach (tbl[k]) begin
            step(tbl[k].rst, tbl[k].init, tbl[k].push, tbl[k].pop, tbl[k].clr, tbl[k].data);
            chk($sformatf("v%0d_count", k), int'(w_count[0]), tbl[k].cnt);
            chk($sformatf("v%0d_top", k),   int'(w_top[0]),   int'(tbl[k].top));
            chk($sformatf("v%0d_empty", k), int'(w_empty[0]), int'(tbl[k].e));
            chk($sformatf("v%0d_full", k),  int'(w_full[0]),  int'(tbl[k].f));
            chk($sformatf("v%0d_ovf", k),   int'(w_ovf[0]),   int'(tbl[k].o));
            chk($sformatf("v%0d_unf", k),   int'(w_unf[0]),   int'(tbl[k].u));
        end

        // Wrap-mode overflow: five pushes into four slots lose the oldest.
        step(1, 0, 0, 0, 0, 12'h000);
        for (int n = 1; n <= 5; n++) step(0, 0, 1, 0, 0, AW'(n));
        chk("wrap_count", int'(w_count[1]), 4);
        chk("wrap_top",   int'(w_top[1]),   5);
        chk("wrap_ovf",   int'(w_ovf[1]),   1);
        chk("wrap_full",  int'(w_full[1]),  1);
        for (int n = 4; n >= 2; n--) begin
            step(0, 0, 0, 1, 0, 12'h000);
            chk($sformatf("wrap_pop_top%0d", n), int'(w_top[1]), n);
        end
        step(0, 0, 0, 1, 0, 12'h000);
        chk("wrap_last_top",   int'(w_top[1]),   0);
        chk("wrap_last_empty", int'(w_empty[1]), 1);
        chk("wrap_last_unf",   int'(w_unf[1]),   0);

        // Replace on a full stack raises no flag in either mode.
        step(1, 0, 0, 0, 0, 12'h000);
        for (int n = 0; n < 4; n++) step(0, 0, 1, 0, 0, AW'(12'h0A0 + n));
        step(0, 0, 1, 1, 0, 12'hABC);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("repl_full_top%0d", d),   int'(w_top[d]),   12'hABC);
            chk($sformatf("repl_full_count%0d", d), int'(w_count[d]), 4);
            chk($sformatf("repl_full_ovf%0d", d),   int'(w_ovf[d]),   0);
        end

        // Randomised traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            bit r, i;
            r = ($urandom_range(0, 63) == 0);
            i = ($urandom_range(0, 63) == 0);
            step(r, i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0), AW'($urandom_range(0, 4095)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_call_stack.md
# pc_call_stack

Parametrised hardware return-address stack for the processor's CALL/RET path, generalising the fixed push/pop/RET stack of the single-cycle core. It sits in the data path beside the PC. The controller drives `push`/`pop`, and the stack holds return addresses for RET. It adds configurable width and depth, full/empty status, selectable overflow policy (drop or wrap), a simultaneous push+pop replace operation, and sticky error flags.

## Interface
Parameters:
- `ADDR_WIDTH`, default 12: width of a stored return address.
- `DEPTH`, default 8: number of entries. Must be a power of two and ≥2.
- `WRAP_ON_OVERFLOW`, default 0: selects the full-stack policy.
  - 0: a push into a full stack is dropped.
  - 1: a push into a full stack overwrites the oldest entry.

Ports:
- `clk`  input  1  clock. All state updates occur on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `init`  input  1  synchronous soft clear. Same effect as `rst`.
- `push`  input  1  push `push_data` (CALL).
- `pop`  input  1  pop the top entry (RET).
- `push_data`  input  ADDR_WIDTH  return address to store.
- `err_clr`  input  1  clears the sticky `overflow`/`underflow` flags.
- `top`  output  ADDR_WIDTH  current top-of-stack. Combinational from state. Forced to 0 when empty.
- `count`  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- `empty`  output  1  high when `count`==0.
- `full`  output  1  high when `count`==DEPTH.
- `overflow`  output  1  sticky. Set when a push would exceed DEPTH.
- `underflow`  output  1  sticky. Set when a pop hits an empty stack.

## Operation
- Storage is a circular array `mem[DEPTH]` with write index `wp` ($clog2(DEPTH) bits, wraps mod DEPTH).
- `top` = `mem[wp-1 mod DEPTH]` when `count`>0, otherwise 0.
- `mem` is not reset. Only `wp`, `count` and the flags are reset.
- Priority per cycle: `rst` > `init` > push/pop operation. `err_clr` is evaluated alongside the operation.
- Operation decode:
  - Idle (`push`=0, `pop`=0): no change.
  - Push only, not full: `mem[wp]`←`push_data`, `wp`++, `count`++.
  - Push only, full, `WRAP_ON_OVERFLOW`=0: no state change. `overflow`←1.
  - Push only, full, `WRAP_ON_OVERFLOW`=1: `mem[wp]`←`push_data`, `wp`++, `count` stays DEPTH (oldest entry lost). `overflow`←1.
  - Pop only, not empty: `wp`--, `count`--.
  - Pop only, empty: no state change. `underflow`←1.
  - Push+pop, not empty: replace top. `mem[wp-1]`←`push_data`. `wp` and `count` unchanged. No flag set, even when full.
  - Push+pop, empty: executes as push only. `underflow`←1.
- Sticky flags: `err_clr` clears both flags. If an error event occurs in the same cycle as `err_clr`, that event's flag ends set (set wins).
- Arithmetic: `wp` wraps modulo DEPTH. `count` saturates at DEPTH (wrap mode) and never goes below 0.

## Timing
- Reset values after a `rst` or `init` edge: `count`=0, `wp`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0, `top`=0.
- Latency:
  - A push issued in cycle N is visible on `top`, `count`, `empty` and `full` in cycle N+1.
  - `top` responds combinationally to state, so RET reads `top` in the same cycle it asserts `pop`.
- Flags update on the same edge as the operation that causes them.
- `rst` or `init` asserted mid-sequence discards any concurrent push/pop and clears flags, regardless of `err_clr`.
- No handshake: `push`/`pop` are single-cycle strobes, sampled on every edge.

## Test plan
All scenarios use ADDR_WIDTH=12, DEPTH=4.
1. Fill and empty, WRAP=0.
   - Stimulus: after `rst`, push 0x010, 0x020, 0x030, 0x040 in consecutive cycles.
   - Required: `full`=1, `count`=4, `top`=0x040.
   - Then pop 4×: `top` reads 0x030, 0x020, 0x010, then 0 with `empty`=1.
2. Overflow drop, WRAP=0.
   - Stimulus: push 0x050 into a full stack.
   - Required: `count`=4, `top`=0x040, `overflow`=1.
   - Then `err_clr` alone: `overflow`=0.
3. Overflow wrap, WRAP=1.
   - Stimulus: push 0x001..0x005 into the stack.
   - Required: `count`=4, `top`=0x005, `overflow`=1.
   - Then pop 4×: `top` reads 0x004, 0x003, 0x002, then 0 with `empty`=1 (0x001 lost).
4. Replace.
   - Stimulus: with stack {0x100, 0x200}, assert push+pop with `push_data`=0x2AA.
   - Required: `count`=2, `top`=0x2AA. Then pop: `top`=0x100.
5. Underflow.
   - Stimulus: pop on an empty stack.
   - Required: `underflow`=1, `count`=0.
   - Then push+pop with 0x077 on an empty stack: `count`=1, `top`=0x077, `underflow`=1.
   - Then `err_clr` in the same cycle as another empty pop: `underflow` stays 1.
6. Reset mid-operation.
   - Stimulus: with `count`=3 and `overflow`=1, assert `init` together with `push`.
   - Required: next cycle `count`=0, `empty`=1, `overflow`=0, `top`=0. Same result with `rst`.
